// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor/anilox step monitoring blocks.
package motor_pkg;

    // Period tracker states: waiting for a first edge, filling the average
    // window, and tracking once the window holds a full set of samples.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_TRACK = 2'd2
    } mon_state_t;

    localparam int DEF_TIMEOUT  = 500000;
    localparam int DEF_AVG_LOG2 = 3;
    localparam int DEF_PERIOD_W = 32;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A rising input shows up as a one-cycle 'rise' pulse three clocks later.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    // sh[0], sh[1] form the synchronizer; sh[2] is the previous synced value
    logic [2:0] sh;

    // Shift the async input through the synchronizer and flag 0->1 on the synced copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            rise <= 1'b0;
        end else begin
            sh   <= {sh[1:0], din};
            rise <= sh[1] & ~sh[2];
        end
    end

endmodule

// File: rtl/step_pulse_monitor.sv
// Step pulse train monitor: counts steps, measures an averaged step period,
// detects a stalled train, and counts steps between print marks.
module step_pulse_monitor
    import motor_pkg::*;
#(
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_in,
    input  logic                mark_in,
    input  logic                clr,
    output logic [31:0]         step_count,
    output logic [PERIOD_W-1:0] period_avg,
    output logic                period_valid,
    output logic                running,
    output logic                timeout_pulse,
    output logic [15:0]         steps_per_mark,
    output logic                spm_valid
);

    localparam int WIN    = 1 << AVG_LOG2;
    localparam int SUM_W  = PERIOD_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam logic [PERIOD_W-1:0] TO_VAL   = PERIOD_W'(TIMEOUT);
    localparam logic [FILL_W-1:0]   FILL_END = FILL_W'(WIN - 1);

    logic                          step_edge;
    logic                          mark_edge;
    logic [PERIOD_W-1:0]           period_cnt;
    mon_state_t                    state, state_nx;
    logic                          push;
    logic                          tmo;
    logic [FILL_W-1:0]             fill_cnt;
    logic [WIN-1:0][PERIOD_W-1:0]  win;
    logic [SUM_W-1:0]              sum;
    logic [SUM_W-1:0]              sum_nx;
    logic                          push_d;
    logic [15:0]                   mark_cnt;
    logic                          armed;

    sync_edge u_step_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (step_in),
        .rise (step_edge)
    );

    sync_edge u_mark_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mark_in),
        .rise (mark_edge)
    );

    // Cycles since the last step edge; reloads to 1 so the value seen on the
    // next edge is exactly the edge-to-edge distance, and parks at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst)
            period_cnt <= '0;
        else if (step_edge)
            period_cnt <= PERIOD_W'(1);
        else if (period_cnt < TO_VAL)
            period_cnt <= period_cnt + PERIOD_W'(1);
    end

    // State register for the period tracker
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state and strobes; a step edge takes priority over the timeout
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        tmo      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (step_edge)
                    state_nx = ST_FILL;
            end
            ST_FILL: begin
                if (step_edge) begin
                    push = 1'b1;
                    if (fill_cnt == FILL_END)
                        state_nx = ST_TRACK;
                end else if (period_cnt >= TO_VAL) begin
                    tmo      = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (step_edge) begin
                    push = 1'b1;
                end else if (period_cnt >= TO_VAL) begin
                    tmo      = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign timeout_pulse = tmo;
    assign running       = (state != ST_IDLE);
    assign period_valid  = (state == ST_TRACK);

    // Count pushes while filling so we know when the window is full
    always_ff @(posedge clk) begin
        if (rst || tmo)
            fill_cnt <= '0;
        else if (push && state == ST_FILL)
            fill_cnt <= fill_cnt + FILL_W'(1);
    end

    assign sum_nx = sum + SUM_W'(period_cnt) - SUM_W'(win[WIN-1]);

    // Sample window and running sum; a timeout empties both for a clean refill
    always_ff @(posedge clk) begin
        if (rst || tmo) begin
            win <= '0;
            sum <= '0;
        end else if (push) begin
            for (int i = WIN - 1; i > 0; i--)
                win[i] <= win[i-1];
            win[0] <= period_cnt;
            sum    <= sum_nx;
        end
    end

    // Delayed push marks the cycle in which the new sum is available
    always_ff @(posedge clk) begin
        if (rst)
            push_d <= 1'b0;
        else
            push_d <= push;
    end

    // Registered average; only refreshed after a push, so it holds through IDLE
    always_ff @(posedge clk) begin
        if (rst)
            period_avg <= '0;
        else if (push_d)
            period_avg <= sum[SUM_W-1:AVG_LOG2];
    end

    // Step totals and steps-per-mark; clr overrides any coincident edge, and a
    // step that lands with a mark is counted in the interval the mark opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_count     <= '0;
            mark_cnt       <= '0;
            armed          <= 1'b0;
            steps_per_mark <= '0;
            spm_valid      <= 1'b0;
        end else begin
            spm_valid <= 1'b0;
            if (clr) begin
                step_count <= '0;
                mark_cnt   <= '0;
                armed      <= 1'b0;
            end else begin
                if (step_edge)
                    step_count <= step_count + 32'd1;
                if (mark_edge) begin
                    if (armed) begin
                        steps_per_mark <= mark_cnt;
                        spm_valid      <= 1'b1;
                    end
                    armed    <= 1'b1;
                    mark_cnt <= step_edge ? 16'd1 : 16'd0;
                end else if (step_edge) begin
                    mark_cnt <= sat_inc16(mark_cnt);
                end
            end
        end
    end

endmodule
